rshp_vfifo: RTL and testbench
=============================

RSHP_VFIFO -- requirements
Module: rshp_vfifo

Interface
REQ-001 Parameter DW, default 512: data-port width in bits, multiple of 64; BW = DW/8 bytes per port beat.
REQ-002 Parameter NWORD, default 2: storage depth in DW-wide words, range 2..8; DEPTH_B = NWORD*BW bytes.
REQ-003 Parameter AF_LVL, default BW: afull asserts when free bytes < AF_LVL.
REQ-004 clk  in  1  single clock, rising edge; all state updates on it.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of contents, pointers and occupancy.
REQ-007 wr_req  in  1  write request.
REQ-008 wr_byte  in  $clog2(BW)+1  bytes to write this beat; byte 0 = wr_data[7:0].
REQ-009 wr_data  in  DW  write data; bytes >= wr_byte are ignored.
REQ-010 wr_gnt  out  1  combinational; write accepted this cycle.
REQ-011 rd_req  in  1  read request.
REQ-012 rd_byte  in  $clog2(BW)+1  bytes to read this beat.
REQ-013 rd_gnt  out  1  combinational; read accepted this cycle.
REQ-014 rd_data  out  DW  registered read data; oldest byte in [7:0].
REQ-015 rd_vld  out  1  registered; rd_data valid this cycle.
REQ-016 occ  out  $clog2(DEPTH_B)+1  registered stored-byte count.
REQ-017 free  out  $clog2(DEPTH_B)+1  DEPTH_B - occ.
REQ-018 afull, empty  out  1 each  free < AF_LVL; occ == 0.
REQ-019 err  out  1  registered one-cycle pulse on illegal request.

Function
REQ-020 wr_gnt = wr_req & !flush & wr_byte <= BW & wr_byte <= free (occupancy at start of cycle, no same-cycle read credit).
REQ-021 rd_gnt = rd_req & !flush & rd_byte <= BW & rd_byte <= occ (no same-cycle write bypass).
REQ-022 Granted write stores wr_byte bytes at wptr onward in byte order, wrapping modulo DEPTH_B; other bytes unchanged.
REQ-023 Granted read: next cycle rd_vld=1 and rd_data holds rd_byte bytes from rptr (wrapping), upper bytes zero; latency exactly 1 cycle.
REQ-024 rd_vld=0 in cycles after an ungranted read; rd_data then holds its previous value.
REQ-025 wptr/rptr advance by granted byte count modulo DEPTH_B; occ += granted wr_byte - granted rd_byte in one update.
REQ-026 wr_byte==0 or rd_byte==0 with request: granted, no state change; rd_vld=1 with rd_data all zero.
REQ-027 wr_byte>BW or rd_byte>BW with request: not granted, err pulses next cycle, state unchanged.
REQ-028 Ungranted legal request (insufficient space/data): no state change, no err; requester retries.
REQ-029 flush: next cycle occ=0, pointers 0, rd_vld=0; flush overrides same-cycle requests.

Reset
REQ-030 reset: wptr, rptr, occ=0; free=DEPTH_B; empty=1; afull=(DEPTH_B<AF_LVL); rd_vld=0; rd_data=0; err=0.
REQ-031 reset mid-operation discards all stored data; storage array contents need not be cleared.
REQ-032 reset has priority over flush and all requests.

Structure
REQ-033 Shared package rshp_pkg holds byte-count width functions and the DEPTH_B/BW localparam derivations.
REQ-034 One sub-module rshp_rot: parametrised byte rotator used for write alignment and read extraction.
REQ-035 Storage is flops or byte-enabled RAM; no multi-cycle paths.

Verification (DW=64, BW=8, NWORD=2, DEPTH_B=16)
REQ-036 Write 5 bytes 0x01..05, write 7 bytes 0x06..0C, read 8 -> next cycle rd_data bytes 01..08, rd_vld=1, occ=4.
REQ-037 Pointers at 14, write 6 bytes 0xA0..A5, read 6 -> rd_data A0..A5 contiguous across wrap, upper 2 bytes 0.
REQ-038 occ=12, write 6 -> wr_gnt=0, occ stays 12; write 4 -> occ=16, free=0, afull=1.
REQ-039 occ=4, write 8 + read 4 same cycle -> both granted, occ=8; occ=4, read 6 -> rd_gnt=0, rd_vld=0 next cycle.
REQ-040 wr_byte=9 -> wr_gnt=0, err=1 one cycle; flush with write same cycle -> occ=0, empty=1.
REQ-041 reset asserted at occ=10 -> next cycle occ=0, rd_vld=0; a subsequent write of 3 bytes then read of 3 returns exactly those 3 bytes.

Source files
------------

// File: rtl/rshp_pkg.sv
// Shared width and size helpers for the byte-reshaping FIFO.
package rshp_pkg;

  // Bytes carried by one data-port beat.
  function automatic int unsigned calc_bw(input int unsigned dw);
    return dw / 8;
  endfunction

  // Total storage in bytes.
  function automatic int unsigned calc_depth_b(input int unsigned nword, input int unsigned dw);
    return nword * (dw / 8);
  endfunction

  // Width of a per-beat byte count (must hold the value BW itself).
  function automatic int unsigned bcnt_w(input int unsigned bw);
    return $clog2(bw) + 1;
  endfunction

  // Width of an occupancy count (must hold the value DEPTH_B itself).
  function automatic int unsigned occ_w(input int unsigned depth_b);
    return $clog2(depth_b) + 1;
  endfunction

endpackage

// File: rtl/rshp_rot.sv
// Element rotator. LEFT=1: o[j] = i[(j - amt) mod NE]; LEFT=0: o[j] = i[(j + amt) mod NE].
module rshp_rot #(
  parameter int unsigned NE   = 16,
  parameter int unsigned EW   = 8,
  parameter bit          LEFT = 1'b1,
  localparam int unsigned AW  = $clog2(NE)
) (
  input  logic [NE*EW-1:0] i_data,
  input  logic [AW-1:0]    i_amt,
  output logic [NE*EW-1:0] o_data
);

  // Mux per output element over every rotation amount; NE need not be a power of two.
  always_comb begin
    o_data = '0;
    for (int j = 0; j < int'(NE); j++) begin
      for (int k = 0; k < int'(NE); k++) begin
        if (i_amt == AW'(k)) begin
          o_data[j*EW +: EW] = LEFT ? i_data[((j + int'(NE) - k) % int'(NE))*EW +: EW]
                                    : i_data[((j + k) % int'(NE))*EW +: EW];
        end
      end
    end
  end

endmodule

// File: rtl/rshp_vfifo.sv
// Byte-granular FIFO: variable-size writes and reads of up to BW bytes per beat.
module rshp_vfifo
  import rshp_pkg::*;
#(
  parameter int unsigned DW      = 512,
  parameter int unsigned NWORD   = 2,
  parameter int unsigned AF_LVL  = DW / 8,
  localparam int unsigned BW      = calc_bw(DW),
  localparam int unsigned DEPTH_B = calc_depth_b(NWORD, DW),
  localparam int unsigned BCW     = bcnt_w(BW),
  localparam int unsigned OCW     = occ_w(DEPTH_B)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           wr_req,
  input  logic [BCW-1:0] wr_byte,
  input  logic [DW-1:0]  wr_data,
  output logic           wr_gnt,
  input  logic           rd_req,
  input  logic [BCW-1:0] rd_byte,
  output logic           rd_gnt,
  output logic [DW-1:0]  rd_data,
  output logic           rd_vld,
  output logic [OCW-1:0] occ,
  output logic [OCW-1:0] free,
  output logic           afull,
  output logic           empty,
  output logic           err
);

  localparam int unsigned PW = $clog2(DEPTH_B);
  localparam int unsigned MW = DEPTH_B * 8;

  logic [MW-1:0]  r_mem;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [OCW-1:0] r_occ;
  logic [DW-1:0]  r_rd_data;
  logic           r_rd_vld;
  logic           r_err;

  logic [OCW-1:0]     w_free;
  logic               w_wr_legal;
  logic               w_rd_legal;
  logic               w_err;
  logic [MW-1:0]      w_wpad;
  logic [MW-1:0]      w_wdata_al;
  logic [DEPTH_B-1:0] w_wmask_lin;
  logic [DEPTH_B-1:0] w_wmask_al;
  logic [MW-1:0]      w_wbits;
  logic [MW-1:0]      w_rd_al;
  logic [DW-1:0]      w_rd_ext;
  logic [OCW-1:0]     w_wsum;
  logic [OCW-1:0]     w_rsum;
  logic [PW-1:0]      w_wptr_nxt;
  logic [PW-1:0]      w_rptr_nxt;
  logic [OCW-1:0]     w_occ_nxt;

  assign w_free     = OCW'(DEPTH_B) - r_occ;
  assign w_wr_legal = (wr_byte <= BCW'(BW));
  assign w_rd_legal = (rd_byte <= BCW'(BW));
  // Grants look only at start-of-cycle occupancy: no same-cycle credit or bypass.
  assign wr_gnt = wr_req & ~flush & w_wr_legal & (OCW'(wr_byte) <= w_free);
  assign rd_gnt = rd_req & ~flush & w_rd_legal & (OCW'(rd_byte) <= r_occ);
  assign w_err  = ~flush & ((wr_req & ~w_wr_legal) | (rd_req & ~w_rd_legal));

  assign w_wpad = {{(MW - DW){1'b0}}, wr_data};

  // Linear byte-enable for the granted write, before alignment to wptr.
  always_comb begin
    w_wmask_lin = '0;
    for (int b = 0; b < int'(BW); b++) begin
      w_wmask_lin[b] = wr_gnt & (BCW'(b) < wr_byte);
    end
  end

  rshp_rot #(
    .NE   (DEPTH_B),
    .EW   (8),
    .LEFT (1'b1)
  ) u_rot_wdata (
    .i_data (w_wpad),
    .i_amt  (r_wptr),
    .o_data (w_wdata_al)
  );

  rshp_rot #(
    .NE   (DEPTH_B),
    .EW   (1),
    .LEFT (1'b1)
  ) u_rot_wmask (
    .i_data (w_wmask_lin),
    .i_amt  (r_wptr),
    .o_data (w_wmask_al)
  );

  rshp_rot #(
    .NE   (DEPTH_B),
    .EW   (8),
    .LEFT (1'b0)
  ) u_rot_rdata (
    .i_data (r_mem),
    .i_amt  (r_rptr),
    .o_data (w_rd_al)
  );

  // Expand byte enables to bit enables and zero the read bytes beyond rd_byte.
  always_comb begin
    w_wbits  = '0;
    w_rd_ext = '0;
    for (int b = 0; b < int'(DEPTH_B); b++) begin
      w_wbits[b*8 +: 8] = {8{w_wmask_al[b]}};
    end
    for (int b = 0; b < int'(BW); b++) begin
      if (BCW'(b) < rd_byte) begin
        w_rd_ext[b*8 +: 8] = w_rd_al[b*8 +: 8];
      end
    end
  end

  // Pointer and occupancy next-state; pointers wrap modulo DEPTH_B.
  always_comb begin
    w_wsum     = OCW'(r_wptr) + (wr_gnt ? OCW'(wr_byte) : '0);
    w_rsum     = OCW'(r_rptr) + (rd_gnt ? OCW'(rd_byte) : '0);
    w_wptr_nxt = PW'((w_wsum >= OCW'(DEPTH_B)) ? w_wsum - OCW'(DEPTH_B) : w_wsum);
    w_rptr_nxt = PW'((w_rsum >= OCW'(DEPTH_B)) ? w_rsum - OCW'(DEPTH_B) : w_rsum);
    w_occ_nxt  = r_occ + (wr_gnt ? OCW'(wr_byte) : '0) - (rd_gnt ? OCW'(rd_byte) : '0);
  end

  // Byte storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    r_mem <= (r_mem & ~w_wbits) | (w_wdata_al & w_wbits);
  end

  // Control state and registered read port; reset beats flush beats requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_occ    <= '0;
      r_rd_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_occ    <= w_occ_nxt;
      r_rd_vld <= rd_gnt;
      r_err    <= w_err;
      if (rd_gnt) begin
        r_rd_data <= w_rd_ext;
      end
    end
  end

  assign rd_data = r_rd_data;
  assign rd_vld  = r_rd_vld;
  assign occ     = r_occ;
  assign free    = w_free;
  assign afull   = (32'(w_free) < AF_LVL);
  assign empty   = (r_occ == '0);
  assign err     = r_err;

endmodule

// File: tb/tb_rshp_vfifo.sv
// Directed bench for rshp_vfifo at DW=64, NWORD=2 (BW=8, DEPTH_B=16).
module tb_rshp_vfifo;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        wr_req;
  logic [3:0]  wr_byte;
  logic [63:0] wr_data;
  logic        wr_gnt;
  logic        rd_req;
  logic [3:0]  rd_byte;
  logic        rd_gnt;
  logic [63:0] rd_data;
  logic        rd_vld;
  logic [4:0]  occ;
  logic [4:0]  free;
  logic        afull;
  logic        empty;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  rshp_vfifo #(
    .DW    (64),
    .NWORD (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_req  (wr_req),
    .wr_byte (wr_byte),
    .wr_data (wr_data),
    .wr_gnt  (wr_gnt),
    .rd_req  (rd_req),
    .rd_byte (rd_byte),
    .rd_gnt  (rd_gnt),
    .rd_data (rd_data),
    .rd_vld  (rd_vld),
    .occ     (occ),
    .free    (free),
    .afull   (afull),
    .empty   (empty),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at negedge, check grants mid-cycle, then return #1 after posedge.
  task automatic step(input string tag, input logic wr, input logic [3:0] wb,
                      input logic [63:0] wd, input logic rd, input logic [3:0] rb,
                      input logic fl, input logic rs, input logic exp_wg, input logic exp_rg);
    @(negedge clk);
    wr_req  = wr;
    wr_byte = wb;
    wr_data = wd;
    rd_req  = rd;
    rd_byte = rb;
    flush   = fl;
    reset   = rs;
    #1;
    chk({tag, "_wr_gnt"}, 64'(wr_gnt), 64'(exp_wg));
    chk({tag, "_rd_gnt"}, 64'(rd_gnt), 64'(exp_rg));
    @(posedge clk);
    #1;
    wr_req  = 1'b0;
    wr_byte = '0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_byte = '0;
    flush   = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    wr_req  = 1'b0;
    wr_byte = '0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_byte = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_occ",    64'(occ),    64'd0);
    chk("rst_free",   64'(free),   64'd16);
    chk("rst_empty",  64'(empty),  64'd1);
    chk("rst_afull",  64'(afull),  64'd0);
    chk("rst_rd_vld", 64'(rd_vld), 64'd0);
    chk("rst_rd_data", rd_data,    64'd0);
    chk("rst_err",    64'(err),    64'd0);

    // Two writes then a read of 8 bytes.
    step("w5", 1, 5, 64'hFFFF_FF05_0403_0201, 0, 0, 0, 0, 1, 0);
    chk("w5_occ", 64'(occ), 64'd5);
    step("w7", 1, 7, 64'hEE0C_0B0A_0908_0706, 0, 0, 0, 0, 1, 0);
    chk("w7_occ", 64'(occ), 64'd12);
    step("r8", 0, 0, 64'd0, 1, 8, 0, 0, 0, 1);
    chk("r8_vld",  64'(rd_vld), 64'd1);
    chk("r8_data", rd_data, 64'h0807_0605_0403_0201);
    chk("r8_occ",  64'(occ), 64'd4);

    // Simultaneous write 8 and read 4 at occ=4.
    step("wr_rd", 1, 8, 64'h1716_1514_1312_1110, 1, 4, 0, 0, 1, 1);
    chk("wr_rd_data", rd_data, 64'h0000_0000_0C0B_0A09);
    chk("wr_rd_occ",  64'(occ), 64'd8);
    step("r4", 0, 0, 64'd0, 1, 4, 0, 0, 0, 1);
    chk("r4_data",  rd_data, 64'h0000_0000_1312_1110);
    chk("r4_occ",   64'(occ), 64'd4);
    chk("r4_afull", 64'(afull), 64'd0);

    // Read more than stored: refused, rd_vld low, data held.
    step("r6_short", 0, 0, 64'd0, 1, 6, 0, 0, 0, 0);
    chk("r6_short_vld",  64'(rd_vld), 64'd0);
    chk("r6_short_data", rd_data, 64'h0000_0000_1312_1110);
    chk("r6_short_occ",  64'(occ), 64'd4);
    chk("r6_short_err",  64'(err), 64'd0);

    // Fill: occ=12, refuse 6, accept 4 to full.
    step("w8b", 1, 8, 64'h2726_2524_2322_2120, 0, 0, 0, 0, 1, 0);
    chk("w8b_occ",   64'(occ), 64'd12);
    chk("w8b_afull", 64'(afull), 64'd1);
    step("w6_full", 1, 6, 64'h1111_1111_1111_1111, 0, 0, 0, 0, 0, 0);
    chk("w6_full_occ", 64'(occ), 64'd12);
    step("w4", 1, 4, 64'h0000_0000_3332_3130, 0, 0, 0, 0, 1, 0);
    chk("w4_occ",   64'(occ), 64'd16);
    chk("w4_free",  64'(free), 64'd0);
    chk("w4_afull", 64'(afull), 64'd1);
    chk("w4_empty", 64'(empty), 64'd0);
    step("r8b", 0, 0, 64'd0, 1, 8, 0, 0, 0, 1);
    chk("r8b_data", rd_data, 64'h2322_2120_1716_1514);
    chk("r8b_occ",  64'(occ), 64'd8);

    // Flush clears occupancy and pointers.
    step("fl", 0, 0, 64'd0, 0, 0, 1, 0, 0, 0);
    chk("fl_occ",   64'(occ), 64'd0);
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_free",  64'(free), 64'd16);
    chk("fl_vld",   64'(rd_vld), 64'd0);

    // Walk both pointers to 14, then exercise a wrapping write and read.
    step("w8c", 1, 8, 64'h4746_4544_4342_4140, 0, 0, 0, 0, 1, 0);
    step("w6c", 1, 6, 64'h0000_4D4C_4B4A_4948, 0, 0, 0, 0, 1, 0);
    step("r8c", 0, 0, 64'd0, 1, 8, 0, 0, 0, 1);
    chk("r8c_data", rd_data, 64'h4746_4544_4342_4140);
    step("r6c", 0, 0, 64'd0, 1, 6, 0, 0, 0, 1);
    chk("r6c_data", rd_data, 64'h0000_4D4C_4B4A_4948);
    chk("r6c_empty", 64'(empty), 64'd1);
    step("wwrap", 1, 6, 64'h5A5A_A5A4_A3A2_A1A0, 0, 0, 0, 0, 1, 0);
    chk("wwrap_occ", 64'(occ), 64'd6);
    step("rwrap", 0, 0, 64'd0, 1, 6, 0, 0, 0, 1);
    chk("rwrap_data", rd_data, 64'h0000_A5A4_A3A2_A1A0);
    chk("rwrap_vld",  64'(rd_vld), 64'd1);
    chk("rwrap_occ",  64'(occ), 64'd0);

    // Zero-byte requests are granted with no state change.
    step("w0", 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1, 0);
    chk("w0_occ", 64'(occ), 64'd0);
    chk("w0_err", 64'(err), 64'd0);
    step("r0", 0, 0, 64'd0, 1, 0, 0, 0, 0, 1);
    chk("r0_vld",  64'(rd_vld), 64'd1);
    chk("r0_data", rd_data, 64'd0);

    // Oversized requests: refused, one-cycle err pulse.
    step("w9", 1, 9, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 0, 0);
    chk("w9_err", 64'(err), 64'd1);
    chk("w9_occ", 64'(occ), 64'd0);
    step("idle1", 0, 0, 64'd0, 0, 0, 0, 0, 0, 0);
    chk("idle1_err", 64'(err), 64'd0);
    step("r9", 0, 0, 64'd0, 1, 9, 0, 0, 0, 0);
    chk("r9_err", 64'(err), 64'd1);
    chk("r9_vld", 64'(rd_vld), 64'd0);

    // Flush overrides a same-cycle write.
    step("w4d", 1, 4, 64'h0000_0000_6362_6160, 0, 0, 0, 0, 1, 0);
    chk("w4d_occ", 64'(occ), 64'd4);
    chk("w4d_err", 64'(err), 64'd0);
    step("flw", 1, 4, 64'h0000_0000_6766_6564, 0, 0, 1, 0, 0, 0);
    chk("flw_occ",   64'(occ), 64'd0);
    chk("flw_empty", 64'(empty), 64'd1);

    // Reset mid-operation, then a clean 3-byte round trip.
    step("w8e", 1, 8, 64'h5756_5554_5352_5150, 0, 0, 0, 0, 1, 0);
    step("w2e", 1, 2, 64'h0000_0000_0000_5958, 0, 0, 0, 0, 1, 0);
    chk("w2e_occ", 64'(occ), 64'd10);
    step("rst2", 0, 0, 64'd0, 0, 0, 0, 1, 0, 0);
    chk("rst2_occ",  64'(occ), 64'd0);
    chk("rst2_vld",  64'(rd_vld), 64'd0);
    chk("rst2_data", rd_data, 64'd0);
    step("w3", 1, 3, 64'hFFFF_FFFF_FFC3_C2C1, 0, 0, 0, 0, 1, 0);
    chk("w3_occ", 64'(occ), 64'd3);
    step("r3", 0, 0, 64'd0, 1, 3, 0, 0, 0, 1);
    chk("r3_data", rd_data, 64'h0000_0000_00C3_C2C1);
    chk("r3_occ",  64'(occ), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
